// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: owner encoding, port indices and
// default bus widths of the CPU memory interface.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 16;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_P0   = 2'd1;
    localparam owner_t OWN_P1   = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic owner_t owner_of(logic port);
        return port ? OWN_P1 : OWN_P0;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              req0;
    logic              we0;
    logic              lock0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic              lock1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: honours a locked owner up to MAX_BURST grants under contention.
// MEM_ARB_RR_EN selects round-robin contention; otherwise port 1 has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic [1:0]                       req,
    input  owner_t                           owner,
    input  logic [$clog2(MAX_BURST+1)-1:0]   burst_cnt,
    input  logic                             last,
    output logic [1:0]                       gnt
);

    localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);

    logic own_idx;
    logic own_req;
    logic oth_req;
    logic under;

`ifndef MEM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        gnt     = 2'b00;
        own_idx = (owner == OWN_P1);
        own_req = (owner != OWN_NONE) && req[own_idx];
        oth_req = req[!own_idx];
        under   = burst_cnt < BCNT_W'(MAX_BURST);

        if (own_req && (under || !oth_req)) begin
            gnt[own_idx] = 1'b1;
        end else if (own_req) begin
            // Tenure exhausted while the other port waits: it takes the next slot.
            gnt[!own_idx] = 1'b1;
        end else if (req == 2'b01) begin
            gnt = 2'b01;
        end else if (req == 2'b10) begin
            gnt = 2'b10;
        end else if (req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            gnt = (last == PORT1) ? 2'b01 : 2'b10;
`else
            gnt = 2'b10;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared single-port program/data memory with locked bursts.
// Define MEM_ARB_RR_EN for round-robin contention instead of port-1 fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);

    owner_t              owner_q, owner_d;
    logic [BCNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic                last_q, last_d;

    logic [1:0]          req;
    logic [1:0]          gnt_pick;
    logic [1:0]          gnt;
    logic                any_gnt;
    logic                sel;
    logic                sel_we;
    logic                sel_lock;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                rd_pend_q;
    logic                rd_port_q;
    logic [1:0]          rvalid_q;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;

    assign req = {bus.req1, bus.req0};

    mem_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .req       (req),
        .owner     (owner_q),
        .burst_cnt (burst_cnt_q),
        .last      (last_q),
        .gnt       (gnt_pick)
    );

    // No grant may be issued while reset is held, even though the picker sees live requests.
    assign gnt       = rst_n ? gnt_pick : 2'b00;
    assign any_gnt   = |gnt;
    assign sel       = gnt[1];
    assign sel_we    = sel ? bus.we1    : bus.we0;
    assign sel_lock  = sel ? bus.lock1  : bus.lock0;
    assign sel_addr  = sel ? bus.addr1  : bus.addr0;
    assign sel_wdata = sel ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q     <= OWN_NONE;
            burst_cnt_q <= '0;
            last_q      <= PORT1;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
        end
    end

    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;
        if (any_gnt) begin
            last_d = sel;
            if (sel_lock) begin
                owner_d = owner_of(sel);
                if (owner_q != owner_of(sel)) begin
                    burst_cnt_d = BCNT_W'(1);
                end else if (burst_cnt_q < BCNT_W'(MAX_BURST)) begin
                    // Saturate: beyond the limit the count only needs to stay "at limit".
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end else begin
                owner_d     = OWN_NONE;
                burst_cnt_d = '0;
            end
        end else if (owner_q != OWN_NONE && !req[owner_q == OWN_P1]) begin
            owner_d     = OWN_NONE;
            burst_cnt_d = '0;
        end
    end

    always_comb begin
        bus.gnt0      = gnt[0];
        bus.gnt1      = gnt[1];
        bus.mem_en    = mem_en_q;
        bus.mem_we    = mem_we_q;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = mem_wdata_q;
        bus.rvalid0   = rvalid_q[0];
        bus.rvalid1   = rvalid_q[1];
        bus.rdata0    = rdata0_q;
        bus.rdata1    = rdata1_q;
    end

    // Command register plus the read-return tag pipe (command stage, return stage).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_port_q   <= PORT0;
            rvalid_q    <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            mem_en_q  <= any_gnt;
            mem_we_q  <= any_gnt & sel_we;
            rd_pend_q <= any_gnt & ~sel_we;
            if (any_gnt) begin
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
                rd_port_q   <= sel;
            end
            rvalid_q <= {rd_pend_q & rd_port_q, rd_pend_q & ~rd_port_q};
            if (rd_pend_q && rd_port_q == PORT0) begin
                rdata0_q <= bus.mem_rdata;
            end
            if (rd_pend_q && rd_port_q == PORT1) begin
                rdata1_q <= bus.mem_rdata;
            end
        end
    end

endmodule
